// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_pkg                                                                 |
// | Opcodes, forward-select encodings and FSM states for the hazard unit.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package hazard_pkg;

    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] STYPE  = 7'b0100011;
    localparam logic [6:0] SBTYPE = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fwd_select                                                                 |
// | EX operand forward-select: EX/MEM result wins over MEM/WB, x0 never fwds.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_ex,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  reg_write_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  reg_write_wb,
    output logic [1:0]            sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_mem && (rd_mem != '0) && (rd_mem == rs_ex)) begin
            sel = FWD_MEM;
        end else if (reg_write_wb && (rd_wb != '0) && (rd_wb == rs_ex)) begin
            sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl_unit                                                           |
// | ID/EX hazard control: load-use stalls, taken-branch flush, forwarding.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 32,
    parameter int FWD_EN      = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            opcode_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rs1_ex,
    input  logic [REG_ADDR_W-1:0] rs2_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  reg_write_ex,
    input  logic                  mem_read_ex,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  reg_write_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  reg_write_wb,
    input  logic                  branch_taken_ex,
    input  logic                  ctrl_bubble,
    output logic                  pc_load,
    output logic                  if_id_load,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int c_max_depth = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
    localparam int c_cnt_w     = $clog2(c_max_depth) + 1;
    localparam logic [c_cnt_w-1:0] c_stall_reload = c_cnt_w'(LOAD_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_flush_reload = c_cnt_w'(FLUSH_DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]     r_stall_count, r_flush_count;
    logic                 w_stall_inc, w_flush_inc;
    logic                 w_uses_rs1, w_uses_rs2;
    logic                 w_raw_load_use, w_match_ex, w_match_mem, w_raw_hazard;
    logic [1:0]           w_fwd_a, w_fwd_b;

    assign w_uses_rs1 = opcode_id inside {RTYPE, STYPE, SBTYPE, LOAD, OPIMM, JALR};
    assign w_uses_rs2 = opcode_id inside {RTYPE, STYPE, SBTYPE};

    // rd != 0 on the producer side is enough to exclude x0 sources as well
    assign w_raw_load_use = mem_read_ex && (rd_ex != '0) &&
                            ((w_uses_rs1 && (rs1_id == rd_ex)) || (w_uses_rs2 && (rs2_id == rd_ex)));
    assign w_match_ex     = reg_write_ex && (rd_ex != '0) &&
                            ((w_uses_rs1 && (rs1_id == rd_ex)) || (w_uses_rs2 && (rs2_id == rd_ex)));
    assign w_match_mem    = reg_write_mem && (rd_mem != '0) &&
                            ((w_uses_rs1 && (rs1_id == rd_mem)) || (w_uses_rs2 && (rs2_id == rd_mem)));
    assign w_raw_hazard   = (FWD_EN != 0) ? w_raw_load_use : (w_match_ex || w_match_mem);

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_ex(rs1_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .sel(w_fwd_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_ex(rs2_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .sel(w_fwd_b)
    );

    assign fwd_a = ((FWD_EN != 0) && !reset) ? w_fwd_a : FWD_RF;
    assign fwd_b = ((FWD_EN != 0) && !reset) ? w_fwd_b : FWD_RF;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = ctrl_bubble;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;

        // A taken branch overrides any stall or flush in progress
        if (branch_taken_ex) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_flush_inc  = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                w_state_nxt = FLUSH;
                w_cnt_nxt   = c_flush_reload;
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (w_raw_hazard) begin
                        pc_load      = 1'b0;
                        if_id_load   = 1'b0;
                        id_ex_bubble = 1'b1;
                        w_stall_inc  = 1'b1;
                        if ((LOAD_LAT > 1) && (FWD_EN != 0)) begin
                            w_state_nxt = STALL;
                            w_cnt_nxt   = c_stall_reload;
                        end
                    end
                end
                STALL: begin
                    pc_load      = 1'b0;
                    if_id_load   = 1'b0;
                    id_ex_bubble = 1'b1;
                    w_stall_inc  = 1'b1;
                    if (r_cnt <= c_cnt_one) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
                FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (r_cnt <= c_cnt_one) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        if (reset) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_stall_inc  = 1'b0;
            w_flush_inc  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= RUN;
            r_cnt         <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall_inc && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_ctrl_unit                                                        |
// | Directed bench: three configurations driven from shared pipeline inputs.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode_id;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic       reg_write_ex, mem_read_ex, reg_write_mem, reg_write_wb;
    logic       branch_taken_ex, ctrl_bubble;

    // a: LOAD_LAT=1 FLUSH_DEPTH=1 FWD_EN=1; b: LOAD_LAT=3 FLUSH_DEPTH=2 CNT_W=2; c: FWD_EN=0
    logic        w_a_pc, w_a_ifl, w_a_fl, w_a_bub;
    logic [1:0]  w_a_fa, w_a_fb;
    logic [31:0] w_a_sc, w_a_fc;
    logic        w_b_pc, w_b_ifl, w_b_fl, w_b_bub;
    logic [1:0]  w_b_fa, w_b_fb;
    logic [1:0]  w_b_sc, w_b_fc;
    logic        w_c_pc, w_c_ifl, w_c_fl, w_c_bub;
    logic [1:0]  w_c_fa, w_c_fb;
    logic [31:0] w_c_sc, w_c_fc;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clock = ~clock;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .FLUSH_DEPTH(1), .CNT_W(32), .FWD_EN(1)) u_a (
        .clock(clock), .reset(reset), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
        .mem_read_ex(mem_read_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .rd_wb(rd_wb),
        .reg_write_wb(reg_write_wb), .branch_taken_ex(branch_taken_ex), .ctrl_bubble(ctrl_bubble),
        .pc_load(w_a_pc), .if_id_load(w_a_ifl), .if_id_flush(w_a_fl), .id_ex_bubble(w_a_bub),
        .fwd_a(w_a_fa), .fwd_b(w_a_fb), .stall_count(w_a_sc), .flush_count(w_a_fc)
    );

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(2), .FWD_EN(1)) u_b (
        .clock(clock), .reset(reset), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
        .mem_read_ex(mem_read_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .rd_wb(rd_wb),
        .reg_write_wb(reg_write_wb), .branch_taken_ex(branch_taken_ex), .ctrl_bubble(ctrl_bubble),
        .pc_load(w_b_pc), .if_id_load(w_b_ifl), .if_id_flush(w_b_fl), .id_ex_bubble(w_b_bub),
        .fwd_a(w_b_fa), .fwd_b(w_b_fb), .stall_count(w_b_sc), .flush_count(w_b_fc)
    );

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_LAT(1), .FLUSH_DEPTH(1), .CNT_W(32), .FWD_EN(0)) u_c (
        .clock(clock), .reset(reset), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
        .mem_read_ex(mem_read_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .rd_wb(rd_wb),
        .reg_write_wb(reg_write_wb), .branch_taken_ex(branch_taken_ex), .ctrl_bubble(ctrl_bubble),
        .pc_load(w_c_pc), .if_id_load(w_c_ifl), .if_id_flush(w_c_fl), .id_ex_bubble(w_c_bub),
        .fwd_a(w_c_fa), .fwd_b(w_c_fb), .stall_count(w_c_sc), .flush_count(w_c_fc)
    );

    task automatic idle();
        opcode_id = 7'b0000000; rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0;
        rd_ex = 0; rd_mem = 0; rd_wb = 0; reg_write_ex = 0; mem_read_ex = 0;
        reg_write_mem = 0; reg_write_wb = 0; branch_taken_ex = 0; ctrl_bubble = 0;
    endtask

    // load x5 in EX, add x6,x5,x7 in ID
    task automatic load_use();
        opcode_id = 7'b0110011; rs1_id = 5; rs2_id = 7;
        rd_ex = 5; mem_read_ex = 1; reg_write_ex = 1;
    endtask

    task automatic test_reset();
        idle(); reset = 1; rd_mem = 3; reg_write_mem = 1; rs1_ex = 3;
        @(negedge clock); @(negedge clock); #1;
        n_total++; if (w_a_pc !== 1'b0) $display("FAIL rst_pc_load got=%0d exp=0", w_a_pc); else n_pass++;
        n_total++; if (w_a_ifl !== 1'b0) $display("FAIL rst_if_id_load got=%0d exp=0", w_a_ifl); else n_pass++;
        n_total++; if (w_a_fl !== 1'b1) $display("FAIL rst_if_id_flush got=%0d exp=1", w_a_fl); else n_pass++;
        n_total++; if (w_a_bub !== 1'b1) $display("FAIL rst_bubble got=%0d exp=1", w_a_bub); else n_pass++;
        n_total++; if (w_a_fa !== 2'b00) $display("FAIL rst_fwd_a got=%0d exp=0", w_a_fa); else n_pass++;
        @(negedge clock); reset = 0; idle(); #1;
        n_total++; if (w_a_sc !== 0 || w_b_sc !== 0) $display("FAIL rst_stall_count got=%0d/%0d exp=0", w_a_sc, w_b_sc); else n_pass++;
        n_total++; if (w_a_fc !== 0 || w_b_fc !== 0) $display("FAIL rst_flush_count got=%0d/%0d exp=0", w_a_fc, w_b_fc); else n_pass++;
        n_total++; if ({w_a_pc, w_a_ifl, w_a_fl, w_a_bub} !== 4'b1100) $display("FAIL run_outputs got=%b exp=1100", {w_a_pc, w_a_ifl, w_a_fl, w_a_bub}); else n_pass++;
        ctrl_bubble = 1; #1;
        n_total++; if ({w_a_pc, w_a_bub} !== 2'b11) $display("FAIL ctrl_bubble got=%b exp=11", {w_a_pc, w_a_bub}); else n_pass++;
        ctrl_bubble = 0;
    endtask

    task automatic test_load_use();
        @(negedge clock); idle(); load_use(); #1;
        n_total++; if ({w_a_pc, w_a_ifl, w_a_bub} !== 3'b001) $display("FAIL lu_a_stall got=%b exp=001", {w_a_pc, w_a_ifl, w_a_bub}); else n_pass++;
        n_total++; if ({w_b_pc, w_c_pc} !== 2'b00) $display("FAIL lu_bc_stall got=%b exp=00", {w_b_pc, w_c_pc}); else n_pass++;
        @(negedge clock); idle(); #1;
        n_total++; if (w_a_pc !== 1'b1 || w_a_sc !== 1) $display("FAIL lu_a_release pc=%0d sc=%0d exp pc=1 sc=1", w_a_pc, w_a_sc); else n_pass++;
        n_total++; if (w_c_pc !== 1'b1 || w_c_sc !== 1) $display("FAIL lu_c_release pc=%0d sc=%0d exp pc=1 sc=1", w_c_pc, w_c_sc); else n_pass++;
        n_total++; if ({w_b_pc, w_b_bub} !== 2'b01) $display("FAIL lu_b_stall2 got=%b exp=01", {w_b_pc, w_b_bub}); else n_pass++;
        @(negedge clock); #1;
        n_total++; if ({w_b_pc, w_b_bub} !== 2'b01) $display("FAIL lu_b_stall3 got=%b exp=01", {w_b_pc, w_b_bub}); else n_pass++;
        @(negedge clock); #1;
        n_total++; if (w_b_pc !== 1'b1 || w_b_sc !== 2'd3) $display("FAIL lu_b_release pc=%0d sc=%0d exp pc=1 sc=3", w_b_pc, w_b_sc); else n_pass++;
    endtask

    task automatic test_no_hazard();
        @(negedge clock); idle(); mem_read_ex = 1; reg_write_ex = 1; rd_ex = 0; opcode_id = 7'b0110011; #1;
        n_total++; if (w_a_pc !== 1'b1) $display("FAIL x0_no_stall got=%0d exp=1", w_a_pc); else n_pass++;
        rd_ex = 5; rs1_id = 5; opcode_id = 7'b0110111; #1;
        n_total++; if (w_a_pc !== 1'b1) $display("FAIL lui_no_rs1 got=%0d exp=1", w_a_pc); else n_pass++;
        rs1_id = 1; rs2_id = 5; opcode_id = 7'b0010011; #1;
        n_total++; if (w_a_pc !== 1'b1) $display("FAIL opimm_no_rs2 got=%0d exp=1", w_a_pc); else n_pass++;
        opcode_id = 7'b0100011; #1;
        n_total++; if (w_a_pc !== 1'b0) $display("FAIL store_rs2_stall got=%0d exp=0", w_a_pc); else n_pass++;
        idle(); opcode_id = 7'b0110011; rs1_id = 9; rd_mem = 9; reg_write_mem = 1; #1;
        n_total++; if ({w_a_pc, w_c_pc} !== 2'b10) $display("FAIL mem_raw a/c got=%b exp=10", {w_a_pc, w_c_pc}); else n_pass++;
        idle();
    endtask

    task automatic test_forwarding();
        @(negedge clock); idle();
        rd_mem = 3; rd_wb = 3; reg_write_mem = 1; reg_write_wb = 1; rs1_ex = 3; #1;
        n_total++; if (w_a_fa !== 2'b01) $display("FAIL fwd_mem_prio got=%0d exp=1", w_a_fa); else n_pass++;
        n_total++; if (w_c_fa !== 2'b00) $display("FAIL fwd_disabled got=%0d exp=0", w_c_fa); else n_pass++;
        rd_mem = 0; #1;
        n_total++; if (w_a_fa !== 2'b10) $display("FAIL fwd_wb got=%0d exp=2", w_a_fa); else n_pass++;
        rs2_ex = 4; rd_wb = 4; rd_mem = 4; reg_write_mem = 0; #1;
        n_total++; if (w_a_fb !== 2'b10 || w_a_fa !== 2'b00) $display("FAIL fwd_b_wb got=%0d/%0d exp=2/0", w_a_fb, w_a_fa); else n_pass++;
        rd_wb = 0; rs2_ex = 0; #1;
        n_total++; if (w_a_fb !== 2'b00) $display("FAIL fwd_x0 got=%0d exp=0", w_a_fb); else n_pass++;
        idle();
    endtask

    task automatic test_flush();
        @(negedge clock); idle(); branch_taken_ex = 1; #1;
        n_total++; if ({w_a_pc, w_a_fl, w_a_bub, w_b_pc, w_b_fl} !== 5'b11111) $display("FAIL br_cycle1 got=%b exp=11111", {w_a_pc, w_a_fl, w_a_bub, w_b_pc, w_b_fl}); else n_pass++;
        @(negedge clock); idle(); #1;
        n_total++; if ({w_a_fl, w_b_pc, w_b_fl} !== 3'b011) $display("FAIL br_cycle2 got=%b exp=011", {w_a_fl, w_b_pc, w_b_fl}); else n_pass++;
        n_total++; if (w_a_fc !== 1 || w_b_fc !== 2'd1) $display("FAIL br_flush_count got=%0d/%0d exp=1/1", w_a_fc, w_b_fc); else n_pass++;
        @(negedge clock); #1;
        n_total++; if (w_b_fl !== 1'b0) $display("FAIL br_b_done got=%0d exp=0", w_b_fl); else n_pass++;
    endtask

    task automatic test_branch_priority();
        @(negedge clock); idle(); load_use(); branch_taken_ex = 1; #1;
        n_total++; if ({w_a_pc, w_a_fl, w_b_pc} !== 3'b111) $display("FAIL prio_flush got=%b exp=111", {w_a_pc, w_a_fl, w_b_pc}); else n_pass++;
        @(negedge clock); idle(); #1;
        n_total++; if (w_a_sc !== 1 || w_a_fc !== 2) $display("FAIL prio_counts sc=%0d fc=%0d exp 1/2", w_a_sc, w_a_fc); else n_pass++;
        @(negedge clock); load_use(); #1;
        n_total++; if (w_b_pc !== 1'b0) $display("FAIL abort_stall_entry got=%0d exp=0", w_b_pc); else n_pass++;
        @(negedge clock); idle(); branch_taken_ex = 1; #1;
        n_total++; if ({w_b_pc, w_b_fl, w_b_bub} !== 3'b111) $display("FAIL abort_to_flush got=%b exp=111", {w_b_pc, w_b_fl, w_b_bub}); else n_pass++;
        @(negedge clock); idle(); #1;
        n_total++; if ({w_b_pc, w_b_fl} !== 2'b11) $display("FAIL abort_flush2 got=%b exp=11", {w_b_pc, w_b_fl}); else n_pass++;
        @(negedge clock); #1;
        n_total++; if ({w_b_pc, w_b_fl} !== 2'b10) $display("FAIL abort_done got=%b exp=10", {w_b_pc, w_b_fl}); else n_pass++;
        n_total++; if (w_b_sc !== 2'd3 || w_b_fc !== 2'd3) $display("FAIL saturate sc=%0d fc=%0d exp 3/3", w_b_sc, w_b_fc); else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clock); idle(); branch_taken_ex = 1;
        @(negedge clock); idle(); reset = 1; #1;
        n_total++; if ({w_b_pc, w_b_ifl, w_b_fl} !== 3'b001) $display("FAIL rst_in_flush got=%b exp=001", {w_b_pc, w_b_ifl, w_b_fl}); else n_pass++;
        @(negedge clock); reset = 0; #1;
        n_total++; if ({w_b_pc, w_b_fl, w_b_bub} !== 3'b100) $display("FAIL post_rst_run got=%b exp=100", {w_b_pc, w_b_fl, w_b_bub}); else n_pass++;
        n_total++; if (w_b_sc !== 0 || w_b_fc !== 0 || w_a_fc !== 0 || w_b_fa !== 2'b00) $display("FAIL post_rst_counts bsc=%0d bfc=%0d afc=%0d fwd=%0d exp 0", w_b_sc, w_b_fc, w_a_fc, w_b_fa); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle(); reset = 1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_forwarding();
        test_flush();
        test_branch_priority();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the ID-stage hazard detector for the 5-stage RISC-V pipeline. Adds the following:
- EX-stage operand forwarding selects.
- Multi-cycle load-use stalls.
- Multi-cycle wrong-path flush after a taken branch.
- Saturating stall/flush performance counters.

It sits between ID and EX. It drives PC/IF-ID load enables, IF/ID flush and the ID/EX bubble mux, and feeds forwarding selects to the EX operand muxes.

Parameters:
REG_ADDR_W, 5, register-address width
LOAD_LAT, 1, bubble cycles per load-use hazard (>=1)
FLUSH_DEPTH, 1, cycles IF/ID flush is held after a taken branch (>=1)
CNT_W, 32, performance counter width
FWD_EN, 1, 1 = forward and stall only on load-use; 0 = no forwarding, stall on any RAW vs EX/MEM

Ports:
clock  in  1  system clock
reset  in  1  reset; synchronous and active-high
opcode_id  in  7  opcode of instruction in ID
rs1_id, rs2_id  in  REG_ADDR_W  ID source registers
rs1_ex, rs2_ex  in  REG_ADDR_W  EX source registers
rd_ex  in  REG_ADDR_W  EX destination
reg_write_ex  in  1  EX writes rd
mem_read_ex  in  1  EX is a load
rd_mem  in  REG_ADDR_W  EX/MEM destination
reg_write_mem  in  1  EX/MEM writes rd
rd_wb  in  REG_ADDR_W  MEM/WB destination
reg_write_wb  in  1  MEM/WB writes rd
branch_taken_ex  in  1  branch/jump resolved taken in EX
ctrl_bubble  in  1  controller-requested ID/EX bubble
pc_load  out  1  PC write enable
if_id_load  out  1  IF/ID write enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_bubble  out  1  select zero control into ID/EX
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
stall_count  out  CNT_W  cycles stalled
flush_count  out  CNT_W  taken-branch events

Behaviour:
- Source usage:
  - uses_rs1 for opcodes R 0110011, S 0100011, SB 1100011, LOAD 0000011, OP-IMM 0010011, JALR 1100111.
  - uses_rs2 for R, S and SB only.
  - A register address of x0 never creates a hazard or a forward.
- Forwarding (combinational, FWD_EN=1):
  - fwd_a=01 if reg_write_mem && rd_mem!=0 && rd_mem==rs1_ex.
  - Else fwd_a=10 if reg_write_wb && rd_wb!=0 && rd_wb==rs1_ex.
  - Else fwd_a=00.
  - fwd_b is the same using rs2_ex.
  - With FWD_EN=0, both selects are forced to 00.
- raw_hazard, FWD_EN=1: mem_read_ex && rd_ex!=0 && (uses_rs1&&rs1_id==rd_ex || uses_rs2&&rs2_id==rd_ex).
- raw_hazard, FWD_EN=0: a match of rs1_id/rs2_id against rd_ex (reg_write_ex) or rd_mem (reg_write_mem). The regfile is write-through, so WB is not checked.
- FSM states: RUN, STALL, FLUSH, plus down-counter cnt of width clog2(max(LOAD_LAT,FLUSH_DEPTH))+1.
- RUN:
  - If branch_taken_ex: outputs pc_load=1, if_id_load=1, if_id_flush=1, id_ex_bubble=1; flush_count++. If FLUSH_DEPTH>1, next state is FLUSH with cnt=FLUSH_DEPTH-1.
  - Else if raw_hazard: outputs pc_load=0, if_id_load=0, id_ex_bubble=1; stall_count++. If LOAD_LAT>1 and FWD_EN=1, next state is STALL with cnt=LOAD_LAT-1. With FWD_EN=0, the hazard re-evaluates each cycle, so no STALL state is used.
  - Else: pc_load=1, if_id_load=1, if_id_flush=0, id_ex_bubble=ctrl_bubble.
- STALL:
  - Outputs as for a RUN hazard; stall_count++.
  - cnt decrements each cycle; when cnt==1, return to RUN.
  - branch_taken_ex in STALL aborts the stall and is handled exactly as in RUN (branch priority).
- FLUSH:
  - Outputs pc_load=1, if_id_load=1, if_id_flush=1, id_ex_bubble=1.
  - cnt decrements; when cnt==1, return to RUN.
  - A new branch_taken_ex reloads cnt=FLUSH_DEPTH-1 and increments flush_count.
- Branch priority: branch_taken_ex always beats raw_hazard in the same cycle.
- Output OR rule: id_ex_bubble is always ORed with ctrl_bubble.
- Counters: both saturate at all-ones and never wrap.
- Reset (synchronous, active-high):
  - Next state RUN, cnt=0, both counters 0.
  - While reset is high: pc_load=0, if_id_load=0, if_id_flush=1, id_ex_bubble=1, fwd=00.
  - Reset mid-stall or mid-flush abandons the sequence; the first post-reset cycle is RUN.
- Latency: all control outputs are combinational from state and inputs (0 cycles). State and counters update on the rising clock edge.

Decomposition:
- Package hazard_pkg holds:
  - Opcode constants (RTYPE, STYPE, SBTYPE, LOAD, OPIMM, JALR).
  - Forward-select encodings FWD_RF, FWD_MEM, FWD_WB.
  - The FSM state enum (RUN, STALL, FLUSH).
- Sub-module fwd_select: purely combinational, instantiated twice (operand A and operand B). Inputs are rs_ex plus the MEM and WB rd/write-enable pairs; output is the 2-bit select.

Test Plan:
- LOAD_LAT=1, FWD_EN=1: load x5 in EX, add x6,x5,x7 in ID -> exactly 1 cycle with pc_load=0, id_ex_bubble=1; stall_count=1.
- LOAD_LAT=3: same sequence -> 3 consecutive stall cycles, state RUN→STALL→STALL→RUN; stall_count=3.
- rd_mem=rd_wb=x3, both writing, rs1_ex=x3 -> fwd_a=01 (EX/MEM priority); rd_mem=x0 -> fwd_a=10; FWD_EN=0 -> fwd_a=00.
- FLUSH_DEPTH=2, branch_taken_ex pulse -> if_id_flush=1 for 2 cycles, pc_load=1 in both; flush_count=1.
- branch_taken_ex and load-use hazard in the same cycle -> flush wins, pc_load=1, stall_count unchanged; same pulse during STALL (LOAD_LAT=3) aborts the stall into flush.
- reset asserted during FLUSH, then released -> next cycle is RUN with counters 0, fwd=00; counter preset to all-ones with one more stall -> stays all-ones.
